// File: rtl/calc_pipe.sv
// rtl/calc_pipe.sv - pipelined Z = A^5 + B^3 + C^2 + AB + AC + BC + A^2*B*C over three operand streams
// Optional feature macro: CALC_ZERO_IDLE_EN (Z forced to 0 whenever pushZ is low)
module calc_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic        pushA,
    input  logic        pushB,
    input  logic        pushC,
    output logic        stopA,
    output logic        stopB,
    output logic        stopC,
    output logic [31:0] Z,
    output logic        pushZ
);

    logic               fullA, fullB, fullC;
    logic signed [31:0] holdA, holdB, holdC;
    logic               launch;
    logic signed [31:0] opA, opB, opC;

    // Pipeline valid bits, stage 1 is loaded on the launch edge
    logic [8:1]         v;

    logic signed [31:0] a1, b1, c1;
    logic signed [31:0] a2, b2, aa2, bb2, cc2, ab2, ac2, bc2;
    logic signed [31:0] a3, a4_3, b3_3, a2bc_3, sx_3, sy_3;
    logic signed [31:0] a5_4, b3_4, a2bc_4, s_4;
    logic signed [31:0] t1_5, t2_5;
    logic signed [31:0] r6, r7, r8;

    // A set launches when every stream is either holding or pushing right now
    assign launch = (fullA | pushA) & (fullB | pushB) & (fullC | pushC);

    // Held operand wins over the port; a push into a full stream is dropped
    assign opA = fullA ? holdA : $signed(A);
    assign opB = fullB ? holdB : $signed(B);
    assign opC = fullC ? holdC : $signed(C);

    // Stop flags are the full flops themselves, so never combinational from a push
    assign stopA = fullA;
    assign stopB = fullB;
    assign stopC = fullC;

    // Per-stream holding registers and full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            fullA <= 1'b0;
            fullB <= 1'b0;
            fullC <= 1'b0;
        end else if (launch) begin
            fullA <= 1'b0;
            fullB <= 1'b0;
            fullC <= 1'b0;
        end else begin
            if (pushA && !fullA) begin
                holdA <= $signed(A);
                fullA <= 1'b1;
            end
            if (pushB && !fullB) begin
                holdB <= $signed(B);
                fullB <= 1'b1;
            end
            if (pushC && !fullC) begin
                holdC <= $signed(C);
                fullC <= 1'b1;
            end
        end
    end

    // Valid bits shift alongside the data; reset kills everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            v <= {v[7:1], launch};
        end
    end

    // Arithmetic datapath, at most one multiply deep per stage, all mod 2^32
    always_ff @(posedge clk) begin
        a1     <= opA;
        b1     <= opB;
        c1     <= opC;

        a2     <= a1;
        b2     <= b1;
        aa2    <= a1 * a1;
        bb2    <= b1 * b1;
        cc2    <= c1 * c1;
        ab2    <= a1 * b1;
        ac2    <= a1 * c1;
        bc2    <= b1 * c1;

        a3     <= a2;
        a4_3   <= aa2 * aa2;
        b3_3   <= bb2 * b2;
        a2bc_3 <= aa2 * bc2;
        sx_3   <= cc2 + ab2;
        sy_3   <= ac2 + bc2;

        a5_4   <= a4_3 * a3;
        b3_4   <= b3_3;
        a2bc_4 <= a2bc_3;
        s_4    <= sx_3 + sy_3;

        t1_5   <= a5_4 + b3_4;
        t2_5   <= a2bc_4 + s_4;

        r6     <= t1_5 + t2_5;
        r7     <= r6;
        r8     <= r7;
    end

    // Registered result and strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            pushZ <= 1'b0;
            Z     <= '0;
        end else begin
            pushZ <= v[8];
`ifdef CALC_ZERO_IDLE_EN
            Z     <= v[8] ? r8 : 32'd0;
`else
            if (v[8]) begin
                Z <= r8;
            end
`endif
        end
    end

endmodule

// File: tb/tb_calc_pipe.sv
// tb/tb_calc_pipe.sv - scoreboard bench for calc_pipe
module tb_calc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, C;
    logic        pushA, pushB, pushC;
    logic        stopA, stopB, stopC;
    logic [31:0] Z;
    logic        pushZ;

    typedef struct {
        logic [31:0] z;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    calc_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .pushA (pushA),
        .pushB (pushB),
        .pushC (pushC),
        .stopA (stopA),
        .stopB (stopB),
        .stopC (stopC),
        .Z     (Z),
        .pushZ (pushZ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d",
                     tag, $signed(got), got, $signed(exp), exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_z(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        r = a*a*a*a*a + b*b*b + c*c + a*b + a*c + b*c + a*a*b*c;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pushA = 1'b0;
        pushB = 1'b0;
        pushC = 1'b0;
    endtask

    // Record the expected result when the current slot completes a triple
    task automatic expect_z(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.z   = ref_z(a, b, c);
        e.due = cyc + 9;
        sb.push_back(e);
    endtask

    task automatic check_stops(input string tag, input logic ea, input logic eb, input logic ec);
        check({tag, "_stopA"}, {31'd0, stopA}, {31'd0, ea});
        check({tag, "_stopB"}, {31'd0, stopB}, {31'd0, eb});
        check({tag, "_stopC"}, {31'd0, stopC}, {31'd0, ec});
    endtask

    // Output monitor: every pulse must match the head of the scoreboard and its due cycle
    always @(negedge clk) begin
        exp_t e;
        if (pushZ === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_pushZ", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("Z_value", Z, e.z);
                check("Z_latency", cyc, e.due);
            end
        end
`ifdef CALC_ZERO_IDLE_EN
        else if (rst === 1'b0) begin
            check("Z_idle_zero", Z, 32'd0);
        end
`endif
    end

    initial begin
        int da, db, dc, dmax;
        int ra, rb, rc;
        rst   = 1'b1;
        A     = '0;
        B     = '0;
        C     = '0;
        pushA = 1'b0;
        pushB = 1'b0;
        pushC = 1'b0;
        step();
        step();
        step();
        check_stops("reset", 1'b0, 1'b0, 1'b0);
        check("reset_pushZ", {31'd0, pushZ}, 32'd0);
        check("reset_Z", Z, 32'd0);
        rst = 1'b0;
        step();

        // Simultaneous push of 1,1,1
        A = 1; B = 1; C = 1;
        pushA = 1; pushB = 1; pushC = 1;
        expect_z(1, 1, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            check_stops("simul", 1'b0, 1'b0, 1'b0);
            step();
        end
        repeat (8) step();

        // Staggered A, B, C
        A = 2; pushA = 1;
        step();
        check_stops("stag1", 1'b1, 1'b0, 1'b0);
        B = 3; pushB = 1;
        step();
        check_stops("stag2", 1'b1, 1'b1, 1'b0);
        C = 4; pushC = 1;
        expect_z(2, 3, 4);
        step();
        check_stops("stag3", 1'b0, 1'b0, 1'b0);

        // Signed corner cases, back to back
        A = -1; B = -1; C = -1; pushA = 1; pushB = 1; pushC = 1;
        expect_z(-1, -1, -1);
        step();
        A = 0; B = 0; C = -3; pushA = 1; pushB = 1; pushC = 1;
        expect_z(0, 0, -3);
        step();
        repeat (12) step();

        // Random triples with independent per-stream delays
        for (int n = 0; n < 5000; n++) begin
            da = $urandom_range(4, 1);
            db = $urandom_range(4, 1);
            dc = $urandom_range(4, 1);
            dmax = da;
            if (db > dmax) dmax = db;
            if (dc > dmax) dmax = dc;
            ra = int'($urandom_range(60, 0)) - 30;
            rb = int'($urandom_range(198, 0)) - 99;
            rc = int'($urandom_range(998, 0)) - 499;
            for (int t = 1; t <= dmax; t++) begin
                check_stops("rnd", da < t, db < t, dc < t);
                if (t == da) begin A = ra; pushA = 1; end
                if (t == db) begin B = rb; pushB = 1; end
                if (t == dc) begin C = rc; pushC = 1; end
                if (t == dmax) expect_z(ra, rb, rc);
                step();
            end
        end
        repeat (12) step();

        // Reset with two operands held and one triple in flight
        A = 5; B = 6; C = 7; pushA = 1; pushB = 1; pushC = 1;
        step();
        A = 9; pushA = 1;
        step();
        B = 8; pushB = 1;
        step();
        check_stops("pre_rst", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        check_stops("post_rst", 1'b0, 1'b0, 1'b0);
        check("post_rst_pushZ", {31'd0, pushZ}, 32'd0);
        rst = 1'b0;
        repeat (15) step();
        A = 1; B = 1; C = 1; pushA = 1; pushB = 1; pushC = 1;
        expect_z(1, 1, 1);
        step();

        for (int w = 0; w < 30 && sb.size() > 0; w++) step();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Reset-time scoreboard purge: the in-flight triple must not appear
    always @(posedge clk) begin
        if (rst === 1'b1) sb.delete();
    end

endmodule

// File: doc/calc_pipe.md
# calc_pipe

Pipelined polynomial evaluator for three independent 32-bit operand streams. Each stream has its own push/stop handshake. The block collects one operand per stream, then computes Z = A⁵ + B³ + C² + A·B + A·C + B·C + A²·B·C. Results leave on a push-only output with fixed latency. The arithmetic is pipelined so that it closes timing at 300 MHz.

## Interface

- One clock; reset is synchronous and active-high.
- No parameters.
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous reset, active-high
- A  in  32  signed operand A, sampled when pushA=1
- B  in  32  signed operand B, sampled when pushB=1
- C  in  32  signed operand C, sampled when pushC=1
- pushA / pushB / pushC  in  1 each  operand valid for that stream
- stopA / stopB / stopC  out  1 each  stream holds an operand and cannot accept another
- Z  out  32  result, two's-complement, valid when pushZ=1
- pushZ  out  1  single-cycle result strobe; there is no backpressure on the output

## Operation

- Each stream has a one-entry holding register plus a full flag (fullA, fullB, fullC).
- A rising edge with pushX=1 and fullX=0 captures X and sets fullX.
- stopX = fullX. It is registered, so it is never combinational from any push input.
- Launch condition: all three full flags are set, or will be set at this edge. At that edge:
  - the triple enters the pipeline;
  - all three full flags clear.
- An operand pushed at the same edge as the launch is used directly. Its stop flag therefore never rises.
- A push while stopX=1 is a protocol violation. The data is dropped and the held operand is kept.
- Arithmetic:
  - all products and sums are signed 32-bit with wrap-around (modulo 2³²);
  - overflow is not detected;
  - operand order in the products does not matter.
- The pipeline is fully pipelined. It accepts one launch per cycle, and results emerge in launch order.
- Pipeline valid bits travel alongside the data. pushZ is the valid bit of the last stage.
- Reset values:
  - stopA, stopB, stopC = 0;
  - pushZ = 0;
  - Z = 0;
  - all full flags and all pipeline valid bits = 0.
- A reset during operation discards any partial operand sets and any in-flight results. No pushZ is issued for them.
- pushZ must never be X after reset.

## Timing

- Latency L = 8. A triple launched at edge N produces pushZ=1 with Z valid in the cycle after edge N+8.
- pushZ lasts exactly one cycle per launched triple.
- stopX rises on the edge after X is captured, if the set is still incomplete. It falls on the launch edge.
- Streams may complete in any order and with any spacing between operands.
- Back-to-back launches give back-to-back pushZ pulses.

## Configuration

- CALC_ZERO_IDLE_EN
  - Defined: Z is forced to 0 in every cycle where pushZ=0.
  - Undefined (default): Z keeps its last valid value between pulses.
- pushZ timing and the result values are identical in both modes.

## Test plan

- Reset, then A=1, B=1, C=1 all pushed at the same edge.
  - Expect stops to stay 0.
  - Expect one pushZ exactly 8 cycles later with Z=7.
- A=2, B=3, C=4 pushed on three consecutive edges in the order A, B, C.
  - Expect stopA high for 2 cycles and stopB high for 1 cycle.
  - Expect Z=149, 8 cycles after the C edge.
- A=-1, B=-1, C=-1.
  - Expect Z=3, which checks signed handling.
- A=0, B=0, C=-3.
  - Expect Z=9.
- 5000 random triples (A in ±30, B in ±99, C in ±499), each stream delayed 1–4 cycles independently.
  - Expect results in order, matching the reference polynomial with 32-bit wrap.
  - Expect no spurious pushZ.
  - Expect every stream that has already pushed, while another stream is still pending, to show stop=1.
- Assert rst while two operands are held and one triple is in flight.
  - Expect stops and pushZ at 0 on the next cycle and no later pushZ.
  - Then push A=1, B=1, C=1 and expect Z=7.
